demux_stream: RTL and testbench

// - Parametrised 1-to-NUM_CH routing demultiplexer for the 32-bit datapath, with registered outputs.
// - Steers one valid/ready input stream to one of NUM_CH output channels selected per beat by in_sel.
// - Each channel holds its last beat in a one-entry slot, so an unselected channel is never disturbed.
// - Sits between a producer (decode/ALU result path) and several consumers (regfile, memory, I/O).

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_slot.sv | 35 +++
 rtl/demux_stream.sv | 91 +++++++++
 tb/tb_demux_stream.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and select-width helper for the stream demultiplexer.
package demux_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned NUM_CH_DEF = 2;

  // Select index width for n channels, never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry register slot: holds a single beat until its consumer takes it.
module demux_slot #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         ready_in,
  output logic         valid_out,
  output logic [W-1:0] data_out,
  output logic         can_load
);

  logic         full;
  logic [W-1:0] data;

  // Slot accepts a new beat when empty or when being drained this cycle.
  assign can_load  = !full || ready_in;
  assign valid_out = full;
  assign data_out  = data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= data_in;
    end else if (ready_in) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream.sv
// 1-to-NUM_CH valid/ready demultiplexer with one-entry slot per channel.
// Optional broadcast routing is enabled with DEMUX_BCAST_EN.
module demux_stream
  import demux_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned NUM_CH = NUM_CH_DEF,
  localparam int unsigned SEL_W  = sel_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic                     err_sel
`ifdef DEMUX_BCAST_EN
  ,
  input  logic                     in_bcast
`endif
);

  logic              bcast;
  logic              in_range;
  logic [NUM_CH-1:0] sel_hot;
  logic [NUM_CH-1:0] can_load;
  logic [NUM_CH-1:0] load;
  logic              accept;

`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Every select code is a real channel when NUM_CH is a power of two.
  generate
    if (NUM_CH == (1 << SEL_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_part_range
      assign in_range = 32'(in_sel) < NUM_CH;
    end
  endgenerate

  // Select decode, ready mux and slot load enables.
  always_comb begin
    sel_hot  = '0;
    in_ready = 1'b1;
    load     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_hot[i] = in_range && (in_sel == SEL_W'(i));
    end
    if (bcast) begin
      in_ready = &can_load;
    end else if (in_range) begin
      in_ready = |(sel_hot & can_load);
    end
    accept = in_valid && in_ready;
    if (accept) begin
      load = bcast ? {NUM_CH{1'b1}} : sel_hot;
    end
  end

  // Flags an accepted beat that addressed no channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else begin
      err_sel <= accept && !bcast && !in_range;
    end
  end

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      demux_slot #(.W(DATA_W)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (load[i]),
        .data_in  (in_data),
        .ready_in (out_ready[i]),
        .valid_out(out_valid[i]),
        .data_out (out_data[i*DATA_W +: DATA_W]),
        .can_load (can_load[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_demux_stream.sv
// Self-checking bench for demux_stream: directed scenarios plus randomized
// traffic against a one-entry-buffer-per-channel reference model.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // NUM_CH = 2 instance
  logic [31:0] d2_in_data;
  logic        d2_in_sel;
  logic        d2_in_valid;
  logic        d2_in_ready;
  logic [63:0] d2_out_data;
  logic [1:0]  d2_out_valid;
  logic [1:0]  d2_out_ready;
  logic        d2_err;

  // NUM_CH = 3 instance
  logic [31:0] d3_in_data;
  logic [1:0]  d3_in_sel;
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [95:0] d3_out_data;
  logic [2:0]  d3_out_valid;
  logic [2:0]  d3_out_ready;
  logic        d3_err;

  demux_stream #(.DATA_W(32), .NUM_CH(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(d2_in_data), .in_sel(d2_in_sel),
    .in_valid(d2_in_valid), .in_ready(d2_in_ready), .out_data(d2_out_data),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .err_sel(d2_err)
`ifdef DEMUX_BCAST_EN
    , .in_bcast(1'b0)
`endif
  );

  demux_stream #(.DATA_W(32), .NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3_in_data), .in_sel(d3_in_sel),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready), .out_data(d3_out_data),
    .out_valid(d3_out_valid), .out_ready(d3_out_ready), .err_sel(d3_err)
`ifdef DEMUX_BCAST_EN
    , .in_bcast(1'b0)
`endif
  );

`ifdef DEMUX_BCAST_EN
  logic [31:0]  d4_in_data;
  logic [1:0]   d4_in_sel;
  logic         d4_in_valid;
  logic         d4_in_ready;
  logic [127:0] d4_out_data;
  logic [3:0]   d4_out_valid;
  logic [3:0]   d4_out_ready;
  logic         d4_err;
  logic         d4_bcast;

  demux_stream #(.DATA_W(32), .NUM_CH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(d4_in_data), .in_sel(d4_in_sel),
    .in_valid(d4_in_valid), .in_ready(d4_in_ready), .out_data(d4_out_data),
    .out_valid(d4_out_valid), .out_ready(d4_out_ready), .err_sel(d4_err),
    .in_bcast(d4_bcast)
  );
`endif

  // Reference model: each channel is a one-entry buffer.
  logic [3:0]       m2_full, m3_full;
  logic [3:0][31:0] m2_data, m3_data;
  logic             m2_err, m3_err;

  function automatic logic exp_ready(input int n, input int sel,
                                     input logic [3:0] full, input logic [3:0] ordy);
    if (sel >= n) return 1'b1;
    return !full[sel] || ordy[sel];
  endfunction

  task automatic model_step(input int n, input logic v, input int sel,
                            input logic [31:0] d, input logic [3:0] ordy,
                            inout logic [3:0] full, inout logic [3:0][31:0] data,
                            output logic err);
    logic rdy;
    rdy = exp_ready(n, sel, full, ordy);
    err = v && rdy && (sel >= n);
    for (int i = 0; i < n; i++) begin
      if (v && rdy && sel == i) begin
        full[i] = 1'b1;
        data[i] = d;
      end else if (ordy[i]) begin
        full[i] = 1'b0;
      end
    end
  endtask

  task automatic idle_inputs();
    d2_in_valid = 1'b0; d2_in_sel = 1'b0; d2_in_data = '0; d2_out_ready = '1;
    d3_in_valid = 1'b0; d3_in_sel = '0;   d3_in_data = '0; d3_out_ready = '1;
`ifdef DEMUX_BCAST_EN
    d4_in_valid = 1'b0; d4_in_sel = '0; d4_in_data = '0; d4_out_ready = '1; d4_bcast = 1'b0;
`endif
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_checks++;
    if (d2_out_valid !== 2'b00 || d2_out_data !== 64'h0 || d2_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_init: valid=%b data=%h err=%b required valid=00 data=0 err=0",
               d2_out_valid, d2_out_data, d2_err);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    // Fill slot 1 and hold it, then reset between clock edges.
    @(negedge clk);
    d2_in_valid = 1'b1; d2_in_sel = 1'b1; d2_in_data = 32'hCAFE_F00D; d2_out_ready = 2'b00;
    @(negedge clk);
    d2_in_valid = 1'b0;
    n_checks++;
    if (d2_out_valid !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_prefill: valid=%b required 10", d2_out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (d2_out_valid !== 2'b00 || d2_out_data !== 64'h0 || d2_err !== 1'b0 ||
        d3_out_valid !== 3'b000 || d3_out_data !== 96'h0 || d3_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: d2 valid=%b data=%h err=%b d3 valid=%b err=%b required all zero",
               d2_out_valid, d2_out_data, d2_err, d3_out_valid, d3_err);
    end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_unicast();
    @(negedge clk);
    d2_in_valid = 1'b1; d2_in_sel = 1'b0; d2_in_data = 32'h1111_0000; d2_out_ready = 2'b11;
    @(negedge clk);
    d2_in_sel = 1'b1; d2_in_data = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (d2_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL unicast_ready: in_ready=%b required 1", d2_in_ready);
    end
    @(negedge clk);
    d2_in_valid = 1'b0;
    n_checks++;
    if (d2_out_valid !== 2'b10 || d2_out_data[63:32] !== 32'hDEAD_BEEF ||
        d2_out_data[31:0] !== 32'h1111_0000) begin
      n_fail++;
      $display("FAIL unicast_out: valid=%b ch1=%h ch0=%h required 10 deadbeef 11110000",
               d2_out_valid, d2_out_data[63:32], d2_out_data[31:0]);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    d2_out_ready = 2'b10; d2_in_valid = 1'b1; d2_in_sel = 1'b0; d2_in_data = 32'hAAAA_0001;
    @(negedge clk);
    d2_in_data = 32'hBBBB_0002;
    #1;
    n_checks++;
    if (d2_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_stall_ready: in_ready=%b required 0", d2_in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (d2_out_valid[0] !== 1'b1 || d2_out_data[31:0] !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL bp_hold: valid0=%b ch0=%h required 1 aaaa0001",
               d2_out_valid[0], d2_out_data[31:0]);
    end
    d2_in_sel = 1'b1; d2_in_data = 32'hCCCC_0003;
    #1;
    n_checks++;
    if (d2_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_other_ready: in_ready=%b required 1", d2_in_ready);
    end
    @(negedge clk);
    d2_in_valid = 1'b0;
    n_checks++;
    if (d2_out_valid !== 2'b11 || d2_out_data[63:32] !== 32'hCCCC_0003 ||
        d2_out_data[31:0] !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL bp_other_out: valid=%b ch1=%h ch0=%h required 11 cccc0003 aaaa0001",
               d2_out_valid, d2_out_data[63:32], d2_out_data[31:0]);
    end
    d2_out_ready = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_throughput();
    logic [31:0] beats[$];
    for (int k = 0; k < 100; k++) beats.push_back($urandom);
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (d2_out_valid[0] !== 1'b1 || d2_out_data[31:0] !== beats[k-1]) begin
          n_fail++;
          $display("FAIL thru_beat%0d: valid0=%b ch0=%h required 1 %h",
                   k - 1, d2_out_valid[0], d2_out_data[31:0], beats[k-1]);
        end
      end
      if (k < 100) begin
        d2_in_valid = 1'b1; d2_in_sel = 1'b0; d2_in_data = beats[k]; d2_out_ready = 2'b01;
        #1;
        n_checks++;
        if (d2_in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL thru_ready%0d: in_ready=%b required 1", k, d2_in_ready);
        end
      end else begin
        d2_in_valid = 1'b0;
      end
    end
    d2_out_ready = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    d3_out_ready = 3'b000; d3_in_valid = 1'b1; d3_in_sel = 2'd0; d3_in_data = 32'h0000_00A5;
    @(negedge clk);
    d3_in_sel = 2'd3; d3_in_data = 32'h5555_5555;
    #1;
    n_checks++;
    if (d3_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL oor_ready: in_ready=%b required 1", d3_in_ready);
    end
    @(negedge clk);
    d3_in_valid = 1'b0;
    n_checks++;
    if (d3_err !== 1'b1 || d3_out_valid !== 3'b001 || d3_out_data[31:0] !== 32'h0000_00A5) begin
      n_fail++;
      $display("FAIL oor_pulse: err=%b valid=%b ch0=%h required 1 001 000000a5",
               d3_err, d3_out_valid, d3_out_data[31:0]);
    end
    @(negedge clk);
    n_checks++;
    if (d3_err !== 1'b0 || d3_out_valid !== 3'b001) begin
      n_fail++;
      $display("FAIL oor_one_cycle: err=%b valid=%b required 0 001", d3_err, d3_out_valid);
    end
    d3_out_ready = 3'b111;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] r2, r3;
    int s2, s3;
    logic v2, v3;
    logic [31:0] x2, x3;
    rst = 1'b1;
    idle_inputs();
    m2_full = '0; m2_data = '0; m2_err = 1'b0;
    m3_full = '0; m3_data = '0; m3_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      n_checks++;
      if (d2_out_valid !== m2_full[1:0] || d2_out_data !== {m2_data[1], m2_data[0]} ||
          d2_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand2_out%0d: valid=%b data=%h err=%b required %b %h 0",
                 k, d2_out_valid, d2_out_data, d2_err, m2_full[1:0], {m2_data[1], m2_data[0]});
      end
      n_checks++;
      if (d3_out_valid !== m3_full[2:0] || d3_out_data !== {m3_data[2], m3_data[1], m3_data[0]} ||
          d3_err !== m3_err) begin
        n_fail++;
        $display("FAIL rand3_out%0d: valid=%b data=%h err=%b required %b %h %b",
                 k, d3_out_valid, d3_out_data, d3_err, m3_full[2:0],
                 {m3_data[2], m3_data[1], m3_data[0]}, m3_err);
      end
      v2 = 1'($urandom_range(0, 3) != 0); s2 = $urandom_range(0, 1);
      x2 = $urandom; r2 = 4'($urandom_range(0, 3));
      v3 = 1'($urandom_range(0, 3) != 0); s3 = $urandom_range(0, 3);
      x3 = $urandom; r3 = 4'($urandom_range(0, 7));
      d2_in_valid = v2; d2_in_sel = 1'(s2); d2_in_data = x2; d2_out_ready = r2[1:0];
      d3_in_valid = v3; d3_in_sel = 2'(s3); d3_in_data = x3; d3_out_ready = r3[2:0];
      #1;
      n_checks++;
      if (d2_in_ready !== exp_ready(2, s2, m2_full, r2) ||
          d3_in_ready !== exp_ready(3, s3, m3_full, r3)) begin
        n_fail++;
        $display("FAIL rand_ready%0d: d2=%b d3=%b required %b %b", k, d2_in_ready, d3_in_ready,
                 exp_ready(2, s2, m2_full, r2), exp_ready(3, s3, m3_full, r3));
      end
      @(posedge clk);
      model_step(2, v2, s2, x2, r2, m2_full, m2_data, m2_err);
      model_step(3, v3, s3, x3, r3, m3_full, m3_data, m3_err);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

`ifdef DEMUX_BCAST_EN
  task automatic test_bcast();
    @(negedge clk);
    d4_out_ready = 4'b0000; d4_in_valid = 1'b1; d4_in_sel = 2'd2; d4_in_data = 32'h0000_0022;
    @(negedge clk);
    d4_out_ready = 4'b1011; d4_bcast = 1'b1; d4_in_sel = 2'd0; d4_in_data = 32'h1234_5678;
    #1;
    n_checks++;
    if (d4_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bcast_blocked: in_ready=%b required 0", d4_in_ready);
    end
    @(negedge clk);
    d4_out_ready = 4'b1111;
    #1;
    n_checks++;
    if (d4_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bcast_ready: in_ready=%b required 1", d4_in_ready);
    end
    @(negedge clk);
    d4_in_valid = 1'b0; d4_bcast = 1'b0;
    n_checks++;
    if (d4_out_valid !== 4'b1111 || d4_out_data !== {4{32'h1234_5678}} || d4_err !== 1'b0) begin
      n_fail++;
      $display("FAIL bcast_out: valid=%b data=%h err=%b required 1111 4x12345678 0",
               d4_out_valid, d4_out_data, d4_err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_throughput();
    test_out_of_range();
`ifdef DEMUX_BCAST_EN
    test_bcast();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
